// File: rtl/shift_register_receiver.sv
// Serial-in / parallel-out receiver modelled on a 595-style shift register, with every pin
// resynchronised into sys_clk. Optional shift counter enabled by SHIFT_REGISTER_RECEIVER_BITCOUNT_EN.
`timescale 1ns/1ps
module shift_register_receiver #(
    parameter int WIDTH = 64
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             ser,
    input  logic             srclk,
    input  logic             rclk,
    input  logic             srclr_n,
    input  logic             oe_n,
    output logic [WIDTH-1:0] data_out,
    output logic             frame_valid,
    output logic             frame_ok,
    output logic [7:0]       bit_count
);

    // Pin bundle order: {oe_n, srclr_n, rclk, srclk, ser}; the active-low controls idle at 1.
    localparam logic [4:0] SYNC_RST = 5'b11000;

    logic [4:0]       meta_q;
    logic [4:0]       sync_q;
    logic             srclk_prev_q;
    logic             rclk_prev_q;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] storage_q, storage_d;
    logic             valid_q, valid_d;

    logic ser_s;
    logic srclk_rise;
    logic rclk_rise;
    logic clr;
    logic oe_off;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta_q       <= SYNC_RST;
            sync_q       <= SYNC_RST;
            srclk_prev_q <= 1'b0;
            rclk_prev_q  <= 1'b0;
        end else begin
            meta_q       <= {oe_n, srclr_n, rclk, srclk, ser};
            sync_q       <= meta_q;
            srclk_prev_q <= sync_q[1];
            rclk_prev_q  <= sync_q[2];
        end
    end

    assign ser_s      = sync_q[0];
    assign srclk_rise = sync_q[1] & ~srclk_prev_q;
    assign rclk_rise  = sync_q[2] & ~rclk_prev_q;
    assign clr        = ~sync_q[3];
    assign oe_off     = sync_q[4];

    // A latch coinciding with a shift captures the pre-shift contents; an active clear wins over both.
    always_comb begin
        shift_d   = shift_q;
        storage_d = storage_q;
        valid_d   = 1'b0;
        if (clr) begin
            shift_d = '0;
        end else if (srclk_rise) begin
            shift_d = {shift_q[WIDTH-2:0], ser_s};
        end
        if (rclk_rise) begin
            storage_d = clr ? '0 : shift_q;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shift_q   <= '0;
            storage_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            storage_q <= storage_d;
            valid_q   <= valid_d;
        end
    end

    assign data_out    = oe_off ? '0 : storage_q;
    assign frame_valid = valid_q;

`ifdef SHIFT_REGISTER_RECEIVER_BITCOUNT_EN
    logic [7:0] count_q, count_d;
    logic       ok_q, ok_d;

    always_comb begin
        count_d = count_q;
        ok_d    = ok_q;
        if (rclk_rise) begin
            ok_d = !clr && (int'(count_q) == WIDTH);
        end
        if (clr) begin
            count_d = 8'd0;
        end else if (rclk_rise) begin
            count_d = srclk_rise ? 8'd1 : 8'd0;
        end else if (srclk_rise && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count_q <= 8'd0;
            ok_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            ok_q    <= ok_d;
        end
    end

    assign bit_count = count_q;
    assign frame_ok  = ok_q;
`else
    assign bit_count = 8'd0;
    assign frame_ok  = 1'b1;
`endif

endmodule

// File: tb/tb_shift_register_receiver.sv
// Scoreboard bench for shift_register_receiver: a bit-level model predicts every latched frame,
// and a monitor compares each frame_valid pulse against the queued expectation.
`timescale 1ns/1ps
module tb_shift_register_receiver;
  localparam int W = 64;

  // clock / reset
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic ser = 1'b0, srclk = 1'b0, rclk = 1'b0, srclr_n = 1'b1, oe_n = 1'b0;
  logic [W-1:0] data_out;
  logic frame_valid, frame_ok;
  logic [7:0] bit_count;

  shift_register_receiver #(.WIDTH(W)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ser(ser), .srclk(srclk), .rclk(rclk),
    .srclr_n(srclr_n), .oe_n(oe_n), .data_out(data_out), .frame_valid(frame_valid),
    .frame_ok(frame_ok), .bit_count(bit_count)
  );

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int pushes = 0;
  logic [W+8:0] exp_q[$];
  logic [W+8:0] mon_e;

  // reference model: what the pins have delivered, in plain terms
  logic [W-1:0] m_shift = '0;
  logic [W-1:0] m_storage = '0;
  int m_count = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_bc(input int n);
`ifdef SHIFT_REGISTER_RECEIVER_BITCOUNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  function automatic void push_exp(input logic [W-1:0] d, input bit ok, input int bc);
    logic ok_e;
`ifdef SHIFT_REGISTER_RECEIVER_BITCOUNT_EN
    ok_e = ok;
`else
    ok_e = 1'b1;
`endif
    exp_q.push_back({d, ok_e, exp_bc(bc)});
    pushes++;
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // driver tasks
  task automatic send_bit(input bit b);
    ser = b;
    wait_cyc(3);
    srclk = 1'b1;
    wait_cyc(3);
    srclk = 1'b0;
    wait_cyc(3);
    m_shift = {m_shift[W-2:0], b};
    if (m_count < 255) m_count++;
  endtask

  task automatic send_frame(input logic [W-1:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (i < 20 && exp_q.size() != 0) begin
      wait_cyc(1);
      i++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_valid_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic latch();
    push_exp(m_shift, m_count == W, 0);
    m_storage = m_shift;
    m_count = 0;
    rclk = 1'b1;
    wait_cyc(3);
    rclk = 1'b0;
    wait_cyc(3);
    drain();
  endtask

  task automatic tied_bit(input bit b);
    ser = b;
    wait_cyc(3);
    push_exp(m_shift, m_count == W, 1);
    m_storage = m_shift;
    srclk = 1'b1;
    rclk = 1'b1;
    wait_cyc(3);
    srclk = 1'b0;
    rclk = 1'b0;
    wait_cyc(3);
    m_shift = {m_shift[W-2:0], b};
    m_count = 1;
    drain();
  endtask

  function automatic logic [W-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // monitor
  always @(negedge sys_clk) begin
    if (sys_rst_n && frame_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame_valid actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        check("latch_data_out", data_out, mon_e[W+8:9]);
        check("latch_frame_ok", {63'd0, frame_ok}, {63'd0, mon_e[8]});
        check("latch_bit_count", {56'd0, bit_count}, {56'd0, mon_e[7:0]});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    int n;
    logic ok_rst;
`ifdef SHIFT_REGISTER_RECEIVER_BITCOUNT_EN
    ok_rst = 1'b0;
`else
    ok_rst = 1'b1;
`endif
    wait_cyc(4);
    check("reset_data_out", data_out, '0);
    check("reset_frame_valid", {63'd0, frame_valid}, '0);
    check("reset_bit_count", {56'd0, bit_count}, '0);
    check("reset_frame_ok", {63'd0, frame_ok}, {63'd0, ok_rst});
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    wait_cyc(4);

    // full known frame
    send_frame(64'd20345674416015432, 64);
    check("count_after_64", {56'd0, bit_count}, {56'd0, exp_bc(64)});
    latch();
    check("known_frame", data_out, 64'd20345674416015432);

    // output enable gating
    oe_n = 1'b1;
    wait_cyc(3);
    check("oe_off_data_out", data_out, '0);
    oe_n = 1'b0;
    wait_cyc(3);
    check("oe_on_data_out", data_out, m_storage);

    // short frame
    send_frame(rand64(), 60);
    latch();

    // clear mid-frame, then latch the cleared register
    send_frame(rand64(), 10);
    srclr_n = 1'b0;
    wait_cyc(4);
    check("clear_keeps_storage", data_out, m_storage);
    check("clear_bit_count", {56'd0, bit_count}, '0);
    srclr_n = 1'b1;
    m_shift = '0;
    m_count = 0;
    wait_cyc(3);
    latch();

    // latch while clear is active
    send_frame(rand64(), 5);
    srclr_n = 1'b0;
    wait_cyc(3);
    m_shift = '0;
    m_count = 0;
    latch();
    srclr_n = 1'b1;
    wait_cyc(3);

    // counter saturation
    send_frame(rand64(), 64);
    send_frame(rand64(), 64);
    send_frame(rand64(), 64);
    send_frame(rand64(), 64);
    send_frame(rand64(), 4);
    check("count_saturated", {56'd0, bit_count}, {56'd0, exp_bc(260)});
    latch();

    // random frames
    for (int k = 0; k < 6; k++) begin
      n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 70) : W;
      send_frame(rand64(), n);
      latch();
      if ($urandom_range(0, 1) == 1) begin
        oe_n = 1'b1;
        wait_cyc(3);
        check("rand_oe_off", data_out, '0);
        oe_n = 1'b0;
        wait_cyc(3);
        check("rand_oe_on", data_out, m_storage);
      end
    end

    // rclk tied to srclk
    for (int k = 0; k < W; k++) tied_bit(1'($urandom_range(0, 1)));
    check("tied_bit_count", {56'd0, bit_count}, {56'd0, exp_bc(1)});

    // reset in the middle of a frame
    send_frame(rand64(), 30);
    sys_rst_n = 1'b0;
    wait_cyc(2);
    check("midreset_data_out", data_out, '0);
    check("midreset_bit_count", {56'd0, bit_count}, '0);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    m_shift = '0;
    m_storage = '0;
    m_count = 0;
    wait_cyc(3);
    v = rand64();
    send_frame(v, W);
    latch();
    check("post_reset_frame", data_out, v);

    wait_cyc(5);
    check("pulse_count", 64'(pulses), 64'(pushes));
    check("queue_empty", 64'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
